// File: rtl/vdp_status_rd.sv
// CPU-side VDP status register reader: synchronises the async read strobe, snapshots
// {F, 5S, C, num} and issues the one-clock rd_tick that clears F in vdp_irq.
module vdp_status_rd #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rd_n_i,
  input  logic       irq_i,
  input  logic       coll_tick_i,
  input  logic       fifth_tick_i,
  input  logic [4:0] fifth_num_i,
  input  logic       ie_i,
  output logic       rd_tick_o,
  output logic [7:0] dout_o,
  output logic       irq_n_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rd_d_q, rd_d_d;
  logic                   flag_5s_q, flag_5s_d;
  logic                   flag_c_q, flag_c_d;
  logic [4:0]             num_q, num_d;
  logic [7:0]             dout_q, dout_d;
  logic                   rd_tick_q, rd_tick_d;
  logic                   irq_n_q, irq_n_d;

  logic rd_s;
  logic rd_start;

  assign rd_s     = sync_q[SYNC_STAGES-1];
  assign rd_start = ~rd_s & rd_d_q;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], rd_n_i};
    rd_d_d    = rd_s;
    flag_5s_d = flag_5s_q;
    flag_c_d  = flag_c_q;
    num_d     = num_q;
    dout_d    = dout_q;
    rd_tick_d = rd_start;
    irq_n_d   = ~(irq_i & ie_i);

    if (rd_start) begin
      dout_d = {irq_i, flag_5s_q, flag_c_q, num_q};
    end

    // Set wins over the read clear so a coincident event shows up on the next read.
    if (coll_tick_i) begin
      flag_c_d = 1'b1;
    end else if (rd_start) begin
      flag_c_d = 1'b0;
    end

    // First fifth sprite is retained until a read frees the latch.
    if (fifth_tick_i && (!flag_5s_q || rd_start)) begin
      flag_5s_d = 1'b1;
      num_d     = fifth_num_i;
    end else if (rd_start) begin
      flag_5s_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q    <= '1;
      rd_d_q    <= 1'b1;
      flag_5s_q <= 1'b0;
      flag_c_q  <= 1'b0;
      num_q     <= 5'd0;
      dout_q    <= 8'h00;
      rd_tick_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      sync_q    <= sync_d;
      rd_d_q    <= rd_d_d;
      flag_5s_q <= flag_5s_d;
      flag_c_q  <= flag_c_d;
      num_q     <= num_d;
      dout_q    <= dout_d;
      rd_tick_q <= rd_tick_d;
      irq_n_q   <= irq_n_d;
    end
  end

  assign rd_tick_o = rd_tick_q;
  assign dout_o    = dout_q;
  assign irq_n_o   = irq_n_q;

endmodule

// File: tb/tb_vdp_status_rd.sv
// Directed bench for vdp_status_rd: latency, snapshot/clear races, strobe length,
// reset mid-strobe and interrupt gating.
module tb_vdp_status_rd;

  localparam int SYNC_STAGES = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rd_n_i;
  logic       irq_i;
  logic       coll_tick_i;
  logic       fifth_tick_i;
  logic [4:0] fifth_num_i;
  logic       ie_i;
  logic       rd_tick_o;
  logic [7:0] dout_o;
  logic       irq_n_o;

  int n_checks = 0;
  int n_errors = 0;
  int tick_cnt = 0;
  int base;

  vdp_status_rd #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rd_n_i      (rd_n_i),
    .irq_i       (irq_i),
    .coll_tick_i (coll_tick_i),
    .fifth_tick_i(fifth_tick_i),
    .fifth_num_i (fifth_num_i),
    .ie_i        (ie_i),
    .rd_tick_o   (rd_tick_o),
    .dout_o      (dout_o),
    .irq_n_o     (irq_n_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (rd_tick_o === 1'b1) tick_cnt++;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Strobe low for low_clks, checking tick timing and the snapshot on the tick edge.
  task automatic read_check(input string tag, input int low_clks, input logic [7:0] exp_dout);
    int b;
    b = tick_cnt;
    rd_n_i = 1'b0;
    step(SYNC_STAGES);
    chk({tag, "_tick_early"}, {7'd0, rd_tick_o}, 8'd0);
    step(1);
    chk({tag, "_tick"}, {7'd0, rd_tick_o}, 8'd1);
    chk({tag, "_dout"}, dout_o, exp_dout);
    step(1);
    chk({tag, "_tick_end"}, {7'd0, rd_tick_o}, 8'd0);
    step(low_clks - SYNC_STAGES - 2);
    rd_n_i = 1'b1;
    step(SYNC_STAGES + 3);
    chk({tag, "_tick_count"}, 8'(tick_cnt - b), 8'd1);
    chk({tag, "_dout_hold"}, dout_o, exp_dout);
  endtask

  task automatic pulse_fifth(input logic [4:0] num);
    fifth_tick_i = 1'b1;
    fifth_num_i  = num;
    step(1);
    fifth_tick_i = 1'b0;
    fifth_num_i  = 5'd0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; rd_n_i = 1'b1; irq_i = 1'b0; coll_tick_i = 1'b0;
    fifth_tick_i = 1'b0; fifth_num_i = 5'd0; ie_i = 1'b0;
    step(2);
    reset_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      chk("idle_dout", dout_o, 8'h00);
      chk("idle_tick", {7'd0, rd_tick_o}, 8'd0);
      chk("idle_irq_n", {7'd0, irq_n_o}, 8'd1);
      step(1);
    end

    irq_i = 1'b1; ie_i = 1'b1;
    coll_tick_i = 1'b1; step(1); coll_tick_i = 1'b0;
    pulse_fifth(5'd7);
    step(1);
    read_check("basic", 6, 8'hE7);
    irq_i = 1'b0;
    step(2);
    read_check("basic2", 6, 8'h07);

    do_reset();
    step(2);
    rd_n_i = 1'b0;
    step(SYNC_STAGES);
    coll_tick_i = 1'b1;
    step(1);
    coll_tick_i = 1'b0;
    chk("race_tick", {7'd0, rd_tick_o}, 8'd1);
    chk("race_dout", dout_o, 8'h00);
    step(3);
    rd_n_i = 1'b1;
    step(SYNC_STAGES + 3);
    read_check("race_next", 6, 8'h20);
    read_check("race_clear", 4, 8'h00);

    pulse_fifth(5'd3);
    step(1);
    pulse_fifth(5'd9);
    step(1);
    read_check("fifth", 5, 8'h43);
    read_check("fifth2", 5, 8'h03);

    base = tick_cnt;
    rd_n_i = 1'b0;
    step(100);
    chk("long_ticks", 8'(tick_cnt - base), 8'd1);
    chk("long_dout", dout_o, 8'h03);
    do_reset();
    chk("rst_dout", dout_o, 8'h00);
    chk("rst_tick", {7'd0, rd_tick_o}, 8'd0);
    step(20);
    chk("rst_refill_ticks", 8'(tick_cnt - base), 8'd2);
    chk("rst_refill_dout", dout_o, 8'h00);
    rd_n_i = 1'b1;
    step(10);
    chk("rst_final_ticks", 8'(tick_cnt - base), 8'd2);

    irq_i = 1'b1; ie_i = 1'b0;
    step(2);
    chk("ie0_irq_n", {7'd0, irq_n_o}, 8'd1);
    ie_i = 1'b1;
    chk("ie1_before", {7'd0, irq_n_o}, 8'd1);
    step(1);
    chk("ie1_irq_n", {7'd0, irq_n_o}, 8'd0);
    ie_i = 1'b0;
    chk("ie0b_before", {7'd0, irq_n_o}, 8'd0);
    step(1);
    chk("ie0b_irq_n", {7'd0, irq_n_o}, 8'd1);
    ie_i = 1'b1;
    step(1);
    chk("ie1b_irq_n", {7'd0, irq_n_o}, 8'd0);
    rd_n_i = 1'b0;
    step(SYNC_STAGES + 1);
    chk("irqrd_tick", {7'd0, rd_tick_o}, 8'd1);
    chk("irqrd_dout", dout_o, 8'h80);
    irq_i = 1'b0;
    chk("irqrd_before", {7'd0, irq_n_o}, 8'd0);
    step(1);
    chk("irqrd_irq_n", {7'd0, irq_n_o}, 8'd1);
    rd_n_i = 1'b1;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
